// File: rtl/sdp_ram_clr.sv
// sdp_ram_clr: simple dual-port RAM (one write, one read port) with per-byte
// write enables, a 1- or 2-cycle read pipeline, selectable read-during-write
// behaviour and a clear engine that fills the array with CLR_VALUE after
// reset and on request.
//
// Handshake summary: there is no backpressure. wr_en / rd_en / clr_req are
// sampled on the rising edge of aclk only while ready=1 and are ignored
// otherwise. Every accepted read produces exactly one data_valid pulse
// RD_LATENCY cycles later. data_out only changes in a data_valid cycle (or
// on reset). dbg_state mirrors the FSM state (0 = CLEAR, 1 = READY).
module sdp_ram_clr #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    RD_LATENCY = 1,
  parameter int                    RW_MODE    = 0,
  parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
  input  logic                    aclk,
  input  logic                    srstn,
  input  logic                    clr_req,
  output logic                    ready,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   addr_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;

  // Reject unsupported configurations while elaborating.
  generate
    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
      $error("sdp_ram_clr: DATA_WIDTH must be a multiple of 8");
    end
    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_rd_latency
      $error("sdp_ram_clr: RD_LATENCY must be 1 or 2");
    end
    if (RW_MODE != 0 && RW_MODE != 1) begin : g_bad_rw_mode
      $error("sdp_ram_clr: RW_MODE must be 0 or 1");
    end
  endgenerate

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_cnt;

  logic                  w_ready;
  logic                  w_clr_we;
  logic                  w_wr_fire;
  logic                  w_rd_fire;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_old;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  r_p1_vld;
  logic [DATA_WIDTH-1:0] r_p1_data;
  logic                  r_data_valid;
  logic [DATA_WIDTH-1:0] r_data_out;

  // State register: reset always lands in CLEAR so the array is rewritten.
  always_ff @(posedge aclk) begin
    if (!srstn) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: leave CLEAR after the last address, re-enter on clr_req.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (&r_cnt) w_next_state = S_READY;
      S_READY: if (clr_req) w_next_state = S_CLEAR;
      default: w_next_state = S_CLEAR;
    endcase
  end

  // Outputs of the FSM: ready flag and clear-engine write strobe.
  always_comb begin
    w_ready  = 1'b0;
    w_clr_we = 1'b0;
    case (r_state)
      S_CLEAR: w_clr_we = 1'b1;
      S_READY: w_ready  = 1'b1;
      default: w_clr_we = 1'b1;
    endcase
  end

  assign ready     = w_ready;
  assign dbg_state = r_state;

  // User traffic is honoured only in READY and never on a reset edge.
  assign w_wr_fire = w_ready & wr_en & srstn;
  assign w_rd_fire = w_ready & rd_en & srstn;

  // Clear address counter: walks 0..DEPTH-1 and wraps back to 0, so it is
  // already at 0 whenever a new clear starts from READY.
  always_ff @(posedge aclk) begin
    if (!srstn) begin
      r_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Storage array: the clear engine owns the write port during CLEAR,
  // otherwise byte-enabled user writes. No reset on the contents.
  always_ff @(posedge aclk) begin
    if (w_clr_we) begin
      r_mem[r_cnt] <= CLR_VALUE;
    end else if (w_wr_fire) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          r_mem[addr_in][8*b +: 8] <= data_in[8*b +: 8];
        end
      end
    end
  end

  assign w_rd_old = r_mem[addr_out];

  // Read word: old contents, with write-first bypass of the enabled bytes
  // when a same-address write lands in the same cycle.
  always_comb begin
    w_rd_word = w_rd_old;
    if (RW_MODE == 1 && w_wr_fire && (addr_in == addr_out)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          w_rd_word[8*b +: 8] = data_in[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline: one or two register stages; data_out holds its value
  // between valid pulses. Reset drops anything in flight.
  always_ff @(posedge aclk) begin
    if (!srstn) begin
      r_p1_vld     <= 1'b0;
      r_p1_data    <= '0;
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else if (RD_LATENCY == 1) begin
      r_p1_vld     <= 1'b0;
      r_data_valid <= w_rd_fire;
      if (w_rd_fire) begin
        r_data_out <= w_rd_word;
      end
    end else begin
      r_p1_vld     <= w_rd_fire;
      if (w_rd_fire) begin
        r_p1_data <= w_rd_word;
      end
      r_data_valid <= r_p1_vld;
      if (r_p1_vld) begin
        r_data_out <= r_p1_data;
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

endmodule

// File: tb/tb_sdp_ram_clr.sv
// Bench for sdp_ram_clr. Two instances share the same stimulus:
//   dut_a: RD_LATENCY=1, RW_MODE=0 (read-first), CLR_VALUE=0
//   dut_b: RD_LATENCY=2, RW_MODE=1 (write-first), CLR_VALUE=5A5A5A5A
// Expected values are hand-computed per instance.
module tb_sdp_ram_clr;

  localparam logic [31:0] CLR_A = 32'h0000_0000;
  localparam logic [31:0] CLR_B = 32'h5A5A_5A5A;

  logic        aclk = 1'b0;
  logic        srstn = 1'b0;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [3:0]  addr_in = '0;
  logic [31:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic [3:0]  addr_out = '0;

  logic        ready_a, ready_b;
  logic [31:0] dout_a, dout_b;
  logic        dv_a, dv_b;
  logic        st_a, st_b;

  int total = 0;
  int bad   = 0;

  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] ea;
    logic [31:0] eb;
  } vec_t;

  vec_t vt[17];

  sdp_ram_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(1), .RW_MODE(0), .CLR_VALUE(CLR_A)
  ) dut_a (
    .aclk(aclk), .srstn(srstn), .clr_req(clr_req), .ready(ready_a),
    .wr_en(wr_en), .wr_be(wr_be), .addr_in(addr_in), .data_in(data_in),
    .rd_en(rd_en), .addr_out(addr_out), .data_out(dout_a), .data_valid(dv_a),
    .dbg_state(st_a)
  );

  sdp_ram_clr #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .RD_LATENCY(2), .RW_MODE(1), .CLR_VALUE(CLR_B)
  ) dut_b (
    .aclk(aclk), .srstn(srstn), .clr_req(clr_req), .ready(ready_b),
    .wr_en(wr_en), .wr_be(wr_be), .addr_in(addr_in), .data_in(data_in),
    .rd_en(rd_en), .addr_out(addr_out), .data_out(dout_b), .data_valid(dv_b),
    .dbg_state(st_b)
  );

  // Clock and watchdog
  always #5 aclk = ~aclk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [3:0] be, input logic [3:0] wa,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra);
    wr_en    = we;
    wr_be    = be;
    addr_in  = wa;
    data_in  = wd;
    rd_en    = re;
    addr_out = ra;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    clr_req = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single read through both instances, 2 cycles, checks latency and data.
  task automatic rd_check(input string nm, input logic [3:0] ra,
                          input logic [31:0] ea, input logic [31:0] eb);
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, ra);
    step();
    idle();
    chk({nm, " a_valid"}, {31'b0, dv_a}, 32'd1);
    chk({nm, " a_data"}, dout_a, ea);
    chk({nm, " b_early"}, {31'b0, dv_b}, 32'd0);
    step();
    chk({nm, " b_valid"}, {31'b0, dv_b}, 32'd1);
    chk({nm, " b_data"}, dout_b, eb);
    chk({nm, " a_pulse"}, {31'b0, dv_a}, 32'd0);
    last_a = ea;
    last_b = eb;
  endtask

  // Count sampled cycles with ready=0 until both instances report ready.
  // With junk=1, writes, reads and clr_req are driven during the clear and
  // must all be ignored.
  task automatic count_clear(input bit junk, output int za, output int zb);
    za = 0;
    zb = 0;
    for (int n = 0; n < 60; n++) begin
      if (ready_a && ready_b) break;
      if (!ready_a) za++;
      if (!ready_b) zb++;
      if (junk) begin
        drive(1'b1, 4'hF, 4'h2, 32'hFFFF_FFFF, 1'b1, 4'h2);
        clr_req = n[0];
      end
      step();
      chk("clear a_valid", {31'b0, dv_a}, 32'd0);
      chk("clear b_valid", {31'b0, dv_b}, 32'd0);
    end
    idle();
  endtask

  initial begin
    int za, zb;

    // Vector table: {we, be, wa, wd, re, ra, exp dut_a, exp dut_b}
    vt[0]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h3, 32'h0000_0000, CLR_B};
    vt[1]  = '{1'b1, 4'h5, 4'h3, 32'hDEADBEEF,  1'b0, 4'h0, 32'h0,         32'h0};
    vt[2]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h3, 32'h00AD00EF,  32'h5AAD5AEF};
    vt[3]  = '{1'b1, 4'hF, 4'h7, 32'hAAAAAAAA,  1'b0, 4'h0, 32'h0,         32'h0};
    vt[4]  = '{1'b1, 4'hF, 4'h7, 32'h11223344,  1'b1, 4'h7, 32'hAAAAAAAA,  32'h11223344};
    vt[5]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h7, 32'h11223344,  32'h11223344};
    vt[6]  = '{1'b1, 4'hA, 4'h7, 32'h55667788,  1'b1, 4'h7, 32'h11223344,  32'h55227744};
    vt[7]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h7, 32'h55227744,  32'h55227744};
    vt[8]  = '{1'b1, 4'hF, 4'h9, 32'hCAFEF00D,  1'b1, 4'h3, 32'h00AD00EF,  32'h5AAD5AEF};
    vt[9]  = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h9, 32'hCAFEF00D,  32'hCAFEF00D};
    vt[10] = '{1'b1, 4'h0, 4'h9, 32'hFFFFFFFF,  1'b1, 4'h9, 32'hCAFEF00D,  32'hCAFEF00D};
    vt[11] = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h9, 32'hCAFEF00D,  32'hCAFEF00D};
    vt[12] = '{1'b1, 4'hF, 4'hF, 32'h12345678,  1'b0, 4'h0, 32'h0,         32'h0};
    vt[13] = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'hF, 32'h12345678,  32'h12345678};
    vt[14] = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h0, 32'h0000_0000, CLR_B};
    vt[15] = '{1'b1, 4'h8, 4'h0, 32'h99000000,  1'b1, 4'hF, 32'h12345678,  32'h12345678};
    vt[16] = '{1'b0, 4'h0, 4'h0, 32'h0,         1'b1, 4'h0, 32'h99000000,  32'h995A5A5A};

    // Reset state
    idle();
    srstn = 1'b0;
    repeat (3) step();
    chk("rst ready_a", {31'b0, ready_a}, 32'd0);
    chk("rst ready_b", {31'b0, ready_b}, 32'd0);
    chk("rst dv_a", {31'b0, dv_a}, 32'd0);
    chk("rst dv_b", {31'b0, dv_b}, 32'd0);
    chk("rst dout_a", dout_a, 32'h0);
    chk("rst dout_b", dout_b, 32'h0);

    // Initial clear: 16 cycles with ready=0
    srstn = 1'b1;
    count_clear(1'b0, za, zb);
    chk("init clear len a", za, 32'd16);
    chk("init clear len b", zb, 32'd16);

    // Stream reads of all 16 addresses on consecutive cycles
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, i[3:0]);
        exp_q.push_back(CLR_B);
      end else begin
        idle();
      end
      step();
      if (i < 16) begin
        chk("stream a_valid", {31'b0, dv_a}, 32'd1);
        chk("stream a_data", dout_a, CLR_A);
      end else begin
        chk("stream a_end", {31'b0, dv_a}, 32'd0);
      end
      if (i == 0) begin
        chk("stream b_first", {31'b0, dv_b}, 32'd0);
      end else begin
        chk("stream b_valid", {31'b0, dv_b}, 32'd1);
        if (exp_q.size() > 0) chk("stream b_data", dout_b, exp_q.pop_front());
        else chk("stream b_queue", 32'd0, 32'd1);
      end
    end
    step();
    chk("stream b_end", {31'b0, dv_b}, 32'd0);
    chk("stream b_hold", dout_b, CLR_B);
    chk("stream a_hold", dout_a, CLR_A);
    last_a = CLR_A;
    last_b = CLR_B;

    // Table-driven writes, reads and collisions, one vector per 2 cycles
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].we, vt[i].be, vt[i].wa, vt[i].wd, vt[i].re, vt[i].ra);
      step();
      idle();
      if (vt[i].re) begin
        last_a = vt[i].ea;
        last_b = vt[i].eb;
      end
      chk($sformatf("vec%0d a_valid", i), {31'b0, dv_a}, {31'b0, vt[i].re});
      chk($sformatf("vec%0d a_data", i), dout_a, last_a);
      chk($sformatf("vec%0d b_early", i), {31'b0, dv_b}, 32'd0);
      step();
      chk($sformatf("vec%0d b_valid", i), {31'b0, dv_b}, {31'b0, vt[i].re});
      chk($sformatf("vec%0d b_data", i), dout_b, last_b);
      chk($sformatf("vec%0d a_pulse", i), {31'b0, dv_a}, 32'd0);
      chk($sformatf("vec%0d a_hold", i), dout_a, last_a);
    end

    // Write at cycle N visible to a read at N+1
    drive(1'b1, 4'hF, 4'h5, 32'h0BADCAFE, 1'b0, 4'h0);
    step();
    rd_check("wr->rd next", 4'h5, 32'h0BADCAFE, 32'h0BADCAFE);

    // clr_req with a read in flight
    drive(1'b1, 4'hF, 4'h2, 32'h77777777, 1'b0, 4'h0);
    step();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h2);
    step();
    idle();
    clr_req = 1'b1;
    chk("clr inflight a_valid", {31'b0, dv_a}, 32'd1);
    chk("clr inflight a_data", dout_a, 32'h77777777);
    step();
    clr_req = 1'b0;
    chk("clr inflight b_valid", {31'b0, dv_b}, 32'd1);
    chk("clr inflight b_data", dout_b, 32'h77777777);
    chk("clr ready_a drop", {31'b0, ready_a}, 32'd0);
    count_clear(1'b1, za, zb);
    chk("req clear len a", za, 32'd16);
    chk("req clear len b", zb, 32'd16);
    rd_check("after clr @2", 4'h2, CLR_A, CLR_B);
    rd_check("after clr @3", 4'h3, CLR_A, CLR_B);
    rd_check("after clr @F", 4'hF, CLR_A, CLR_B);

    // Reset with a read in flight, then reset again mid-clear
    drive(1'b1, 4'hF, 4'h4, 32'h13579BDF, 1'b0, 4'h0);
    step();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h4);
    step();
    idle();
    chk("rst inflight a_valid", {31'b0, dv_a}, 32'd1);
    chk("rst inflight a_data", dout_a, 32'h13579BDF);
    srstn = 1'b0;
    step();
    chk("rst drop b_valid", {31'b0, dv_b}, 32'd0);
    chk("rst drop b_data", dout_b, 32'h0);
    chk("rst drop a_data", dout_a, 32'h0);
    chk("rst drop ready_b", {31'b0, ready_b}, 32'd0);
    srstn = 1'b1;
    repeat (5) step();
    chk("mid clear ready_a", {31'b0, ready_a}, 32'd0);
    srstn = 1'b0;
    step();
    chk("mid rst dv_b", {31'b0, dv_b}, 32'd0);
    chk("mid rst dout_b", dout_b, 32'h0);
    srstn = 1'b1;
    count_clear(1'b1, za, zb);
    chk("restart clear len a", za, 32'd16);
    chk("restart clear len b", zb, 32'd16);
    rd_check("after rst @4", 4'h4, CLR_A, CLR_B);
    rd_check("after rst @0", 4'h0, CLR_A, CLR_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
